// File: rtl/lut_cam_pkg.sv
// lut_cam_pkg: shared helpers and record types for the lut_cam lookup table.
// The entry/response structs describe the default geometry
// (8 entries, 7-bit key, 32-bit data).
package lut_cam_pkg;

   localparam int LC_NR_KEY   = 8;
   localparam int LC_KEY_LEN  = 7;
   localparam int LC_DATA_LEN = 32;

   // Index width for n entries; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int LC_IDX_W = idx_width(LC_NR_KEY);

   typedef struct packed {
      logic                   vld;
      logic [LC_KEY_LEN-1:0]  key;
      logic [LC_DATA_LEN-1:0] data;
   } entry_t;

   typedef struct packed {
      logic                   hit;
      logic [LC_IDX_W-1:0]    idx;
      logic [LC_DATA_LEN-1:0] data;
   } resp_t;

endpackage

// File: rtl/lut_cam_match.sv
// lut_cam_match: combinational match of one key against every table entry.
// Multiple hits resolve to the lowest index; data is taken from that entry
// only. On a miss all outputs are zero.
module lut_cam_match #(
   parameter int NR_KEY   = 8,
   parameter int KEY_LEN  = 7,
   parameter int DATA_LEN = 32,
   parameter int IDX_W    = 3
) (
   input  logic [NR_KEY-1:0]               i_vld,
   input  logic [NR_KEY-1:0][KEY_LEN-1:0]  i_key,
   input  logic [NR_KEY-1:0][DATA_LEN-1:0] i_data,
   input  logic [KEY_LEN-1:0]              i_req_key,
   output logic                            o_hit,
   output logic [IDX_W-1:0]                o_idx,
   output logic [DATA_LEN-1:0]             o_data
);

   // Scan from the top down so the lowest matching index is the last written.
   always_comb begin
      o_hit  = 1'b0;
      o_idx  = '0;
      o_data = '0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (i_vld[i] && (i_key[i] == i_req_key)) begin
            o_hit  = 1'b1;
            o_idx  = IDX_W'(i);
            o_data = i_data[i];
         end
      end
   end

endmodule

// File: rtl/lut_cam.sv
// lut_cam: run-time programmable key->data lookup table with a valid/ready
// request port and one registered response stage.
// Optional feature macro: LUT_CAM_BYPASS_EN -- when defined, a lookup accepted
// in the same cycle as a clear and/or write sees the post-update table.
module lut_cam
   import lut_cam_pkg::*;
#(
   parameter int NR_KEY      = LC_NR_KEY,
   parameter int KEY_LEN     = LC_KEY_LEN,
   parameter int DATA_LEN    = LC_DATA_LEN,
   parameter bit HAS_DEFAULT = 1'b1,
   parameter int IDX_W       = idx_width(NR_KEY)
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_wr_en,
   input  logic [IDX_W-1:0]    i_wr_idx,
   input  logic [KEY_LEN-1:0]  i_wr_key,
   input  logic [DATA_LEN-1:0] i_wr_data,
   input  logic                i_wr_vld,
   input  logic                i_clr,
   input  logic [DATA_LEN-1:0] i_default_out,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [KEY_LEN-1:0]  i_req_key,
   output logic                o_resp_valid,
   input  logic                i_resp_ready,
   output logic [DATA_LEN-1:0] o_resp_data,
   output logic                o_resp_hit,
   output logic [IDX_W-1:0]    o_resp_idx
);

   logic [NR_KEY-1:0]               r_vld;
   logic [NR_KEY-1:0][KEY_LEN-1:0]  r_key;
   logic [NR_KEY-1:0][DATA_LEN-1:0] r_data;

   logic [NR_KEY-1:0]               w_vld_nxt;
   logic [NR_KEY-1:0][KEY_LEN-1:0]  w_key_nxt;
   logic [NR_KEY-1:0][DATA_LEN-1:0] w_data_nxt;

   logic [NR_KEY-1:0]               w_m_vld;
   logic [NR_KEY-1:0][KEY_LEN-1:0]  w_m_key;
   logic [NR_KEY-1:0][DATA_LEN-1:0] w_m_data;

   logic                r_resp_valid;
   logic                r_resp_hit;
   logic [IDX_W-1:0]    r_resp_idx;
   logic [DATA_LEN-1:0] r_resp_data;

   logic                w_req_ready;
   logic                w_accept;
   logic                w_hit;
   logic [IDX_W-1:0]    w_idx;
   logic [DATA_LEN-1:0] w_data;
   logic [DATA_LEN-1:0] w_miss_data;

   // Post-edge table image: clear first, then the indexed write on top.
   // An out-of-range wr_idx matches no entry, so nothing changes.
   always_comb begin
      w_vld_nxt  = r_vld;
      w_key_nxt  = r_key;
      w_data_nxt = r_data;
      for (int i = 0; i < NR_KEY; i++) begin
         if (i_clr) begin
            w_vld_nxt[i] = 1'b0;
         end
         if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
            w_vld_nxt[i]  = i_wr_vld;
            w_key_nxt[i]  = i_wr_key;
            w_data_nxt[i] = i_wr_data;
         end
      end
   end

   // Table storage; reset zeroes every field.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld  <= '0;
         r_key  <= '0;
         r_data <= '0;
      end else begin
         r_vld  <= w_vld_nxt;
         r_key  <= w_key_nxt;
         r_data <= w_data_nxt;
      end
   end

`ifdef LUT_CAM_BYPASS_EN
   // Lookups see the table as it will be after this edge.
   assign w_m_vld  = w_vld_nxt;
   assign w_m_key  = w_key_nxt;
   assign w_m_data = w_data_nxt;
`else
   // Lookups see the table as it stands before this edge.
   assign w_m_vld  = r_vld;
   assign w_m_key  = r_key;
   assign w_m_data = r_data;
`endif

   lut_cam_match #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN),
      .IDX_W    (IDX_W)
   ) u_match (
      .i_vld     (w_m_vld),
      .i_key     (w_m_key),
      .i_data    (w_m_data),
      .i_req_key (i_req_key),
      .o_hit     (w_hit),
      .o_idx     (w_idx),
      .o_data    (w_data)
   );

   assign w_miss_data = HAS_DEFAULT ? i_default_out : '0;
   assign w_req_ready = !r_resp_valid || i_resp_ready;
   assign w_accept    = i_req_valid && w_req_ready;

   // Response stage: load on accept, otherwise drop valid once consumed.
   // Data fields hold their last value after the response is taken.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_resp_valid <= 1'b0;
         r_resp_hit   <= 1'b0;
         r_resp_idx   <= '0;
         r_resp_data  <= '0;
      end else if (w_accept) begin
         r_resp_valid <= 1'b1;
         r_resp_hit   <= w_hit;
         r_resp_idx   <= w_idx;
         r_resp_data  <= w_hit ? w_data : w_miss_data;
      end else if (i_resp_ready) begin
         r_resp_valid <= 1'b0;
      end
   end

   assign o_req_ready  = w_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_hit   = r_resp_hit;
   assign o_resp_idx   = r_resp_idx;
   assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_lut_cam.sv
// tb_lut_cam: directed-vector bench for lut_cam (default geometry) plus a
// second instance built with HAS_DEFAULT=0 sharing the same stimulus.
module tb_lut_cam;
   import lut_cam_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   wr_en;
   logic [LC_IDX_W-1:0]    wr_idx;
   logic [LC_KEY_LEN-1:0]  wr_key;
   logic [LC_DATA_LEN-1:0] wr_data;
   logic                   wr_vld;
   logic                   clr;
   logic [LC_DATA_LEN-1:0] default_out;
   logic                   req_valid;
   logic                   req_ready;
   logic [LC_KEY_LEN-1:0]  req_key;
   logic                   resp_valid;
   logic                   resp_ready;
   logic [LC_DATA_LEN-1:0] resp_data;
   logic                   resp_hit;
   logic [LC_IDX_W-1:0]    resp_idx;

   logic                   nd_req_ready;
   logic                   nd_resp_valid;
   logic [LC_DATA_LEN-1:0] nd_resp_data;
   logic                   nd_resp_hit;
   logic [LC_IDX_W-1:0]    nd_resp_idx;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   lut_cam u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_wr_en       (wr_en),
      .i_wr_idx      (wr_idx),
      .i_wr_key      (wr_key),
      .i_wr_data     (wr_data),
      .i_wr_vld      (wr_vld),
      .i_clr         (clr),
      .i_default_out (default_out),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_key     (req_key),
      .o_resp_valid  (resp_valid),
      .i_resp_ready  (resp_ready),
      .o_resp_data   (resp_data),
      .o_resp_hit    (resp_hit),
      .o_resp_idx    (resp_idx)
   );

   lut_cam #(.HAS_DEFAULT(1'b0)) u_dut_nd (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_wr_en       (wr_en),
      .i_wr_idx      (wr_idx),
      .i_wr_key      (wr_key),
      .i_wr_data     (wr_data),
      .i_wr_vld      (wr_vld),
      .i_clr         (clr),
      .i_default_out (default_out),
      .i_req_valid   (req_valid),
      .o_req_ready   (nd_req_ready),
      .i_req_key     (req_key),
      .o_resp_valid  (nd_resp_valid),
      .i_resp_ready  (resp_ready),
      .o_resp_data   (nd_resp_data),
      .o_resp_hit    (nd_resp_hit),
      .o_resp_idx    (nd_resp_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic resp_t mk(input logic hit, input int idx, input logic [31:0] data);
      resp_t r;
      r.hit  = hit;
      r.idx  = LC_IDX_W'(idx);
      r.data = data;
      return r;
   endfunction

   task automatic chk_resp(input string tag, input resp_t exp);
      chk({tag, ".valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".hit"},   64'(resp_hit),   64'(exp.hit));
      chk({tag, ".idx"},   64'(resp_idx),   64'(exp.idx));
      chk({tag, ".data"},  64'(resp_data),  64'(exp.data));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [6:0] key, input logic [31:0] data, input logic vld);
      wr_en   = 1'b1;
      wr_idx  = LC_IDX_W'(idx);
      wr_key  = key;
      wr_data = data;
      wr_vld  = vld;
      tick();
      wr_en   = 1'b0;
   endtask

   // One lookup with resp_ready=1, then checks the registered response.
   task automatic lookup(input string tag, input logic [6:0] key, input resp_t exp);
      req_valid  = 1'b1;
      req_key    = key;
      resp_ready = 1'b1;
      tick();
      req_valid  = 1'b0;
      chk_resp(tag, exp);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; wr_vld = 1'b0;
      clr = 1'b0; default_out = 32'hDEADBEEF; req_valid = 1'b0; req_key = '0; resp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      chk("rst.valid", 64'(resp_valid), 64'd0);
      chk("rst.data",  64'(resp_data),  64'd0);
      chk("rst.hit",   64'(resp_hit),   64'd0);
      chk("rst.idx",   64'(resp_idx),   64'd0);
      chk("rst.ready", 64'(req_ready),  64'd1);

      // Empty table: miss returns default_out / zero.
      req_valid = 1'b1; req_key = 7'h13;
      #1;
      chk("empty.pre_valid", 64'(resp_valid), 64'd0);
      tick();
      req_valid = 1'b0;
      chk_resp("empty", mk(1'b0, 0, 32'hDEADBEEF));
      chk("empty.nd_valid", 64'(nd_resp_valid), 64'd1);
      chk("empty.nd_hit",   64'(nd_resp_hit),   64'd0);
      chk("empty.nd_data",  64'(nd_resp_data),  64'd0);
      tick();
      chk("drain.valid", 64'(resp_valid), 64'd0);
      chk("drain.hold",  64'(resp_data),  64'hDEADBEEF);

      // Single entry hit.
      wr(2, 7'h13, 32'h1111, 1'b1);
      lookup("hit2", 7'h13, mk(1'b1, 2, 32'h1111));
      chk("hit2.nd_data", 64'(nd_resp_data), 64'h1111);
      chk("hit2.nd_idx",  64'(nd_resp_idx),  64'd2);

      // Duplicate keys: lowest index wins, then invalidation exposes the next.
      wr(1, 7'h33, 32'hA, 1'b1);
      wr(5, 7'h33, 32'hB, 1'b1);
      lookup("dup", 7'h33, mk(1'b1, 1, 32'hA));
      wr(1, 7'h33, 32'hA, 1'b0);
      lookup("inval", 7'h33, mk(1'b1, 5, 32'hB));
      tick();

      // Backpressure: response held for 3 cycles, req_ready low.
      req_valid = 1'b1; req_key = 7'h13; resp_ready = 1'b0;
      tick();
      req_key = 7'h33;
      for (int c = 0; c < 3; c++) begin
         chk_resp("hold", mk(1'b1, 2, 32'h1111));
         chk("hold.ready", 64'(req_ready), 64'd0);
         tick();
      end
      chk_resp("hold.end", mk(1'b1, 2, 32'h1111));
      resp_ready = 1'b1;
      #1;
      chk("release.ready", 64'(req_ready), 64'd1);
      tick();
      chk_resp("release.r1", mk(1'b1, 5, 32'hB));
      req_key = 7'h13;
      tick();
      chk_resp("release.r2", mk(1'b1, 2, 32'h1111));
      req_valid = 1'b0;
      tick();
      chk("release.drain", 64'(resp_valid), 64'd0);

      // Same-cycle clear + write + lookup.
      wr(3, 7'h05, 32'h55, 1'b1);
      clr = 1'b1;
      wr_en = 1'b1; wr_idx = '0; wr_key = 7'h05; wr_data = 32'h77; wr_vld = 1'b1;
      req_valid = 1'b1; req_key = 7'h05;
      tick();
      clr = 1'b0; wr_en = 1'b0; req_valid = 1'b0;
`ifdef LUT_CAM_BYPASS_EN
      chk_resp("clrwr", mk(1'b1, 0, 32'h77));
`else
      chk_resp("clrwr", mk(1'b1, 3, 32'h55));
`endif
      lookup("clr.k05", 7'h05, mk(1'b1, 0, 32'h77));
      lookup("clr.k13", 7'h13, mk(1'b0, 0, 32'hDEADBEEF));
      lookup("clr.k33", 7'h33, mk(1'b0, 0, 32'hDEADBEEF));

      // Reset with a pending, unconsumed response.
      req_valid = 1'b1; req_key = 7'h05; resp_ready = 1'b0;
      tick();
      req_valid = 1'b0;
      chk("prerst.valid", 64'(resp_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2.valid", 64'(resp_valid), 64'd0);
      chk("rst2.data",  64'(resp_data),  64'd0);
      chk("rst2.hit",   64'(resp_hit),   64'd0);
      lookup("rst2.k05", 7'h05, mk(1'b0, 0, 32'hDEADBEEF));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
